// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 serial transmitter (start, 8 data LSB first, stop).
// Frames leave back-to-back while the FIFO holds data; txd and busy are registered.
module uart_tx_fifo #(
    parameter int CLK_PER_HALF_BIT = 435,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  tdata,
    input  logic                        tvalid,
    output logic                        tready,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int BIT   = 2 * CLK_PER_HALF_BIT;
    localparam int CNT_W = $clog2(BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_txd, w_txd_nxt, r_busy;
    logic             w_wr, w_pop, w_have, w_wrap;

    // tready depends only on the registered level, never on a same-edge pop
    assign tready = (r_level < LVL_W'(FIFO_DEPTH));
    assign w_wr   = tvalid && tready;
    assign w_have = (r_level != '0);
    assign w_wrap = (r_cnt == CNT_W'(BIT - 1));
    assign txd    = r_txd;
    assign busy   = r_busy;
    assign level  = r_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_have) w_state_nxt = START;
            START:   if (w_wrap) w_state_nxt = DATA;
            DATA:    if (w_wrap && r_bit == 3'd7) w_state_nxt = STOP;
            STOP:    if (w_wrap) w_state_nxt = w_have ? START : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_pop       = 1'b0;
        w_txd_nxt   = r_txd;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit;
        w_cnt_nxt   = w_wrap ? '0 : r_cnt + CNT_W'(1);
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_txd_nxt = 1'b1;
                if (w_have) begin
                    w_pop       = 1'b1;
                    w_txd_nxt   = 1'b0;
                    w_shift_nxt = r_mem[r_rd_ptr];
                end
            end
            START: if (w_wrap) begin
                w_txd_nxt   = r_shift[0];
                w_shift_nxt = {1'b0, r_shift[7:1]};
                w_bit_nxt   = '0;
            end
            DATA: if (w_wrap) begin
                if (r_bit == 3'd7) begin
                    w_txd_nxt = 1'b1;
                end else begin
                    w_txd_nxt   = r_shift[0];
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                end
            end
            // Popping at the end of the stop bit makes the next start bit abut it
            STOP: if (w_wrap && w_have) begin
                w_pop       = 1'b1;
                w_txd_nxt   = 1'b0;
                w_shift_nxt = r_mem[r_rd_ptr];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_txd    <= 1'b1;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_level  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_txd   <= w_txd_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_level <= r_level + LVL_W'(w_wr) - LVL_W'(w_pop);
            if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= tdata;
        r_shift <= w_shift_nxt;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: every cycle txd/busy/level/tready are compared with a
// frame-schedule model (each accepted byte owns an 80-cycle window starting at max(accept+1, previous end)).
module tb_uart_tx_fifo;
    localparam int CPH   = 4;
    localparam int DEPTH = 4;
    localparam int BIT   = 2 * CPH;
    localparam int FRAME = 10 * BIT;

    logic       clk = 1'b0;
    logic       rst;
    logic       tvalid;
    logic [7:0] tdata;
    logic       tready, txd, busy;
    logic [2:0] level;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_PER_HALF_BIT(CPH), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .tdata(tdata), .tvalid(tvalid),
        .tready(tready), .txd(txd), .busy(busy), .level(level)
    );

    typedef struct {
        int         n;
        int         s;
        logic [7:0] b;
    } frame_t;

    frame_t fq[$];
    int e, last_end, n_cmp, n_bad, busy_cnt, low_cnt;

    function automatic int m_level();
        int l = 0;
        foreach (fq[i]) begin
            if (fq[i].n <= e) l++;
            if (fq[i].s <= e) l--;
        end
        return l;
    endfunction

    function automatic logic m_txd();
        logic t = 1'b1;
        foreach (fq[i]) begin
            if (e >= fq[i].s && e < fq[i].s + FRAME) begin
                int k = (e - fq[i].s) / BIT;
                if (k == 0)      t = 1'b0;
                else if (k == 9) t = 1'b1;
                else             t = fq[i].b[k-1];
            end
        end
        return t;
    endfunction

    function automatic logic m_busy();
        logic bz = 1'b0;
        foreach (fq[i])
            if (e >= fq[i].s && e < fq[i].s + FRAME) bz = 1'b1;
        return bz;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, got, exp);
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] d);
        logic   acc;
        frame_t f;
        tvalid = v;
        tdata  = d;
        acc    = v && (m_level() < DEPTH);
        @(posedge clk);
        e++;
        if (acc) begin
            f.n = e;
            f.s = (e + 1 > last_end) ? e + 1 : last_end;
            f.b = d;
            last_end = f.s + FRAME;
            fq.push_back(f);
        end
        @(negedge clk);
        chk("txd", txd, m_txd());
        chk("busy", busy, m_busy());
        chk("level", level, m_level());
        chk("tready", tready, (m_level() < DEPTH));
        if (busy) busy_cnt++;
        if (!txd) low_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom));
    endtask

    task automatic send_held(input logic [7:0] d);
        int waited = 0;
        logic can;
        do begin
            can = (m_level() < DEPTH);
            tick(1'b1, d);
            waited++;
        end while (!can && waited < 2000);
        if (!can) begin
            n_cmp++;
            n_bad++;
            $error("FAIL accept_timeout byte=%0h", d);
        end
    endtask

    // Called at a negedge: reset is raised between edges to show it acts immediately
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_level", level, 3'd0);
        chk("rst_tready", tready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        fq.delete();
        e = 0;
        last_end = 0;
    endtask

    initial begin
        rst = 1'b1; tvalid = 1'b0; tdata = 8'h00;
        e = 0; last_end = 0; n_cmp = 0; n_bad = 0;
        @(negedge clk);
        async_reset();
        idle(3);

        // single byte 0x55
        busy_cnt = 0;
        tick(1'b1, 8'h55);
        idle(90);
        chk("single_busy_cycles", busy_cnt, 80);

        // back-to-back 0xA3, 0x00
        busy_cnt = 0;
        tick(1'b1, 8'hA3);
        tick(1'b1, 8'h00);
        idle(170);
        chk("b2b_busy_cycles", busy_cnt, 160);

        // full FIFO with bytes 1..8 held on tvalid
        for (int i = 1; i <= 8; i++) send_held(8'(i));
        idle(DEPTH * FRAME + 20);

        // ignored data while full
        for (int i = 0; i < DEPTH + 1; i++) tick(1'b1, 8'($urandom));
        for (int i = 0; i < 30; i++) tick(1'b1, 8'($urandom));
        chk("ignored_level", level, 3'd4);
        idle((DEPTH + 1) * FRAME + 20);

        // reset during bit 3 of 0xF0 with two bytes queued
        tick(1'b1, 8'hF0);
        tick(1'b1, 8'h11);
        tick(1'b1, 8'h22);
        idle(1 + 4 * BIT + 3);
        async_reset();
        idle(200);
        tick(1'b1, 8'h3C);
        idle(90);

        // frame timing 0xFF then 0x00
        busy_cnt = 0; low_cnt = 0;
        tick(1'b1, 8'hFF);
        tick(1'b1, 8'h00);
        idle(170);
        chk("timing_busy_cycles", busy_cnt, 160);
        chk("timing_low_cycles", low_cnt, 80);

        // random traffic
        for (int i = 0; i < 600; i++) tick(($urandom_range(0, 3) == 0), 8'($urandom));
        idle((DEPTH + 1) * FRAME + 20);
        chk("final_level", level, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
